// File: rtl/key_event_queue_pkg.sv
// Shared types and ps2_key field positions for the key event queue.
package key_queue_pkg;

  localparam int KEY_EVENT_W     = 10;
  localparam int KEY_TOGGLE_BIT  = 10;
  localparam int KEY_PRESSED_BIT = 9;
  localparam int KEY_EXT_BIT     = 8;

  typedef struct packed {
    logic       pressed;
    logic       extended;
    logic [7:0] code;
  } key_event_t;

endpackage

// File: rtl/key_event_queue_if.sv
// Bundle of the ps2_key input, CPU pop side and status of the key event queue.
interface key_event_queue_if #(
  parameter int DEPTH = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [10:0]     ps2_key;
  logic            rd;
  logic [9:0]      dout;
  logic            empty;
  logic [ADDR_W:0] count;
  logic            overflow;
  logic            ovf_clr;

  modport master (
    output ps2_key, rd, ovf_clr,
    input  dout, empty, count, overflow
  );

  modport slave (
    input  ps2_key, rd, ovf_clr,
    output dout, empty, count, overflow
  );
endinterface

// File: rtl/key_event_queue_fifo_fwft.sv
// Generic first-word-fall-through queue: register storage, asynchronous read of
// a registered read pointer; a push into a full queue succeeds only alongside a pop.
module fifo_fwft #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (ADDR_W+1)'(DEPTH));
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (pop_ok)  rptr_d = rptr_q + 1'b1;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; the output is forced to zero while nothing is held.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= din_i;
  end

  assign dout_o  = empty_o ? '0 : mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/key_event_queue.sv
// Turns toggle-encoded ps2_key words into queued key events with a sticky overflow flag.
// Define KEY_QUEUE_REPEAT_FILTER_EN to discard typematic repeats of the last make code.
module key_event_queue
  import key_queue_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic           clk_sys,
  input  logic           reset,
  key_event_queue_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);

  key_event_t      ev;
  key_event_t      fifo_dout;
  logic [ADDR_W:0] fifo_count;
  logic            tog, evt_det, push_req, drop, full, empty;
  logic            primed_q, primed_d;
  logic            last_tog_q, last_tog_d;
  logic            ovf_q, ovf_d;

  assign ev      = key_event_t'(bus.ps2_key[KEY_PRESSED_BIT:0]);
  assign tog     = bus.ps2_key[KEY_TOGGLE_BIT];
  assign evt_det = primed_q && (tog != last_tog_q);

`ifdef KEY_QUEUE_REPEAT_FILTER_EN
  logic [8:0] last_make_q, last_make_d;
  logic       lm_vld_q, lm_vld_d;
  logic       match;

  assign match    = lm_vld_q && ({ev.extended, ev.code} == last_make_q);
  assign push_req = evt_det && !(ev.pressed && match);

  always_comb begin
    last_make_d = last_make_q;
    lm_vld_d    = lm_vld_q;
    if (evt_det) begin
      if (ev.pressed) begin
        last_make_d = {ev.extended, ev.code};
        lm_vld_d    = 1'b1;
      end else if (match) begin
        lm_vld_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      last_make_q <= '0;
      lm_vld_q    <= 1'b0;
    end else begin
      last_make_q <= last_make_d;
      lm_vld_q    <= lm_vld_d;
    end
  end
`else
  assign push_req = evt_det;
`endif

  // A full queue only loses the event when the CPU is not popping the same cycle.
  assign drop = push_req && full && !bus.rd;

  always_comb begin
    primed_d   = 1'b1;
    last_tog_d = (!primed_q || evt_det) ? tog : last_tog_q;
    ovf_d      = ovf_q;
    if (drop)             ovf_d = 1'b1;
    else if (bus.ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      primed_q   <= 1'b0;
      last_tog_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      primed_q   <= primed_d;
      last_tog_q <= last_tog_d;
      ovf_q      <= ovf_d;
    end
  end

  fifo_fwft #(
    .WIDTH (KEY_EVENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_sys),
    .rst_i   (reset),
    .push_i  (push_req),
    .pop_i   (bus.rd),
    .din_i   (ev),
    .dout_o  (fifo_dout),
    .empty_o (empty),
    .full_o  (full),
    .count_o (fifo_count)
  );

  assign bus.dout     = fifo_dout;
  assign bus.empty    = empty;
  assign bus.count    = fifo_count;
  assign bus.overflow = ovf_q;

endmodule
